// File: rtl/bbot_uart_route_arbiter_if.sv
// Request, line-monitor and route-select bundle between the UART mux
// requesters and the route arbiter.
interface bbot_uart_route_arbiter_if;
    logic [1:0] req;
    logic [2:0] tx_line;
    logic [2:0] select_route;
    logic [1:0] grant;
    logic       busy;

    modport master (
        output req,
        output tx_line,
        input  select_route,
        input  grant,
        input  busy
    );

    modport slave (
        input  req,
        input  tx_line,
        output select_route,
        output grant,
        output busy
    );
endinterface

// File: rtl/bbot_uart_route_arbiter.sv
// Route arbiter for the shared BBot UART mux: switches or releases a route
// only after its lines have been idle for a full guard interval.
module bbot_uart_route_arbiter #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int GUARD_BITS    = 12,
    parameter int MAX_HOLD_BITS = 8192
) (
    input logic                       clock,
    input logic                       reset,
    bbot_uart_route_arbiter_if.slave  bus
);

    localparam int Q  = GUARD_BITS * CLKS_PER_BIT;
    localparam int QW = $clog2(Q + 1);
    localparam int HW = (MAX_HOLD_BITS > 0) ? $clog2(MAX_HOLD_BITS + 1) : 1;
    localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [QW-1:0] Q_MAX  = QW'(Q);
    localparam logic [HW-1:0] H_MAX  = HW'(MAX_HOLD_BITS);
    localparam logic [PW-1:0] P_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic          HOLD_EN = (MAX_HOLD_BITS != 0);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRAIN   = 3'd1;
    localparam logic [2:0] S_SWITCH  = 3'd2;
    localparam logic [2:0] S_GRANTED = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]    state_q, state_d;
    logic          route_q, route_d;
    logic          target_q, target_d;
    logic          last_q, last_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    settle_q, settle_d;
    logic [1:0]    grant_q, grant_d;
    logic          busy_q, busy_d;

    logic tick;
    logic active;
    logic quiet_sat;
    logic pick;

    assign tick      = (pre_q == P_LAST);
    assign quiet_sat = (quiet_q == Q_MAX);

    // Route 0 carries tx0/tx1, route 1 carries tx1/tx2; low = mid-frame.
    assign active = route_q ? (~bus.tx_line[1] | ~bus.tx_line[2])
                            : (~bus.tx_line[0] | ~bus.tx_line[1]);

    always_comb begin
        state_d  = state_q;
        route_d  = route_q;
        target_d = target_q;
        last_d   = last_q;
        hold_d   = hold_q;
        settle_d = settle_q;
        pick     = 1'b0;

        pre_d = tick ? '0 : pre_q + 1'b1;

        if (active)
            quiet_d = '0;
        else if (quiet_sat)
            quiet_d = quiet_q;
        else
            quiet_d = quiet_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    pick     = (bus.req == 2'b11) ? ~last_q : bus.req[1];
                    target_d = pick;
                    if (pick == route_q) begin
                        state_d = S_GRANTED;
                        hold_d  = '0;
                    end else begin
                        state_d = S_DRAIN;
                        quiet_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (!bus.req[target_q]) begin
                    state_d = S_IDLE;
                end else if (quiet_sat) begin
                    state_d  = S_SWITCH;
                    route_d  = target_q;
                    settle_d = 2'd2;
                end
            end
            S_SWITCH: begin
                // Two cycles let the mux's registered output follow the new select.
                if (settle_q <= 2'd1) begin
                    state_d = S_GRANTED;
                    hold_d  = '0;
                end else begin
                    settle_d = settle_q - 2'd1;
                end
            end
            S_GRANTED: begin
                last_d = route_q;
                if (tick && bus.req[~route_q] && hold_q != H_MAX)
                    hold_d = hold_q + 1'b1;
                if (!bus.req[route_q] || (HOLD_EN && hold_q == H_MAX)) begin
                    state_d = S_RELEASE;
                    quiet_d = '0;
                end
            end
            S_RELEASE: begin
                if (quiet_sat)
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        grant_d = (state_d == S_GRANTED) ? (route_d ? 2'b10 : 2'b01) : 2'b00;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            route_q  <= 1'b0;
            target_q <= 1'b0;
            last_q   <= 1'b1;
            quiet_q  <= '0;
            hold_q   <= '0;
            pre_q    <= '0;
            settle_q <= 2'd0;
            grant_q  <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            route_q  <= route_d;
            target_q <= target_d;
            last_q   <= last_d;
            quiet_q  <= quiet_d;
            hold_q   <= hold_d;
            pre_q    <= pre_d;
            settle_q <= settle_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.select_route = {2'b00, route_q};
    assign bus.grant        = grant_q;
    assign bus.busy         = busy_q;

endmodule

// File: doc/bbot_uart_route_arbiter.md
# bbot_uart_route_arbiter

Arbiter and sequencer for the BBot FPGA's shared UART mux (`BBot_UartSmartMux`). It owns the mux's `selectRoute` input and shares the serial path between two requesters: route 0 (XBee TX → BBone RX) and route 1 (BBone TX → voice module RX). It changes routes only after the outgoing route's lines have been quiet for a guard interval, so no UART frame is ever cut mid-character. It also enforces a maximum hold time while the other side is waiting.

## Interface
- `CLKS_PER_BIT`, 434, clocks per UART bit time (50 MHz / 115200).
- `GUARD_BITS`, 12, bit times a route's lines must be continuously idle before a switch or release completes; Q = `GUARD_BITS`*`CLKS_PER_BIT` clocks.
- `MAX_HOLD_BITS`, 8192, bit times an owner may hold the grant while the other requester waits; 0 disables preemption.

- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 2: level request; bit 0 requests route 0, bit 1 requests route 1. Held high for as long as the path is wanted.
- `tx_line` in 3: monitored mux TX inputs {tx2,tx1,tx0}; idle-high UART lines.
- `select_route` out 3: drives mux `selectRoute`; {2'b00, route}.
- `grant` out 2: one-hot grant, or 00.
- `busy` out 1: high in every state except IDLE.

## Operation
- Reset values: state IDLE, `select_route`=000, `grant`=00, `busy`=0, `last_owner`=1 (so `req[0]` wins the first tie), all counters 0.
- Route line sets: route 0 watches tx0 and tx1; route 1 watches tx1 and tx2. Any watched line low means "active".
- Quiet counter: counts clocks while the current route's lines are all high, clears to 0 on any active cycle, and saturates at Q.
- Bit prescaler: free-running 0..`CLKS_PER_BIT`-1; produces a one-clock tick at wrap.
- States:
  - IDLE: if no `req` bit is set, stay. If exactly one is set, choose it. If both are set, choose the route that is not `last_owner`. If the chosen route equals the current route, go to GRANTED. Otherwise clear the quiet counter and go to DRAIN.
  - DRAIN: when the quiet counter reaches Q, go to SWITCH. If `req` for the target drops first, return to IDLE with the route unchanged.
  - SWITCH: update `select_route` to the target, load a 2-cycle settle count (covers the mux's registered output), then go to GRANTED.
  - GRANTED: assert `grant`[owner]; set `last_owner`=owner; clear the hold counter on entry.
    - The hold counter increments on each bit tick while the other `req` bit is high and holds otherwise.
    - When `req`[owner] drops, or when `MAX_HOLD_BITS`≠0 and the hold count reaches `MAX_HOLD_BITS`: clear `grant` and go to RELEASE. If both happen in the same cycle, handle it as a normal release.
  - RELEASE: wait until the quiet counter reaches Q (clear it on entry), then go to IDLE. `select_route` is parked at the last route.
- A preempted owner must stop transmitting when its `grant` falls. Frames already in flight are absorbed by the RELEASE guard.
- Counter widths: quiet counter is clog2(Q+1) bits; hold counter is clog2(`MAX_HOLD_BITS`+1) bits; neither may wrap.

## Timing
- All outputs are registered and change only on `clock` rising edges, or asynchronously on `reset`.
- Same-route request from IDLE: `grant` rises one clock after the edge that samples `req` high.
- Different-route request: `select_route` changes one clock after the quiet counter reaches Q in DRAIN; `grant` rises 2 clocks after `select_route` changes.
- `grant` falls one clock after `req`[owner] is sampled low, or after the hold limit is reached.
- `select_route` never changes outside SWITCH, and never while `grant`≠00.
- `reset` mid-operation (any state): immediate return to the reset values, with `select_route`=000 and no guard wait.

## Test plan
Run with `CLKS_PER_BIT`=4, `GUARD_BITS`=2 (Q=8), `MAX_HOLD_BITS`=16.
- Reset: assert `reset` → `select_route`=000, `grant`=00, `busy`=0 without waiting for a clock edge.
- Same-route grant: with lines idle, set `req`=01 → `grant`=01 one clock later, `select_route` stays 000; drop `req` → `grant`=00 next clock, then `busy`=0 after 8 idle clocks.
- Route switch: set `req`=10 with lines idle → `select_route`=001 exactly 8 idle clocks after entering DRAIN, `grant`=10 2 clocks after that.
- Guard restart: pulse tx1 low for 1 clock at DRAIN clock 5 → `select_route` does not change until 8 consecutive idle clocks after tx1 returns high.
- Preemption and round-robin: owner 0 holds while `req`=11 → `grant` falls after 16 bit ticks (64 clocks), then after the guard `grant`=10, `select_route`=001. When owner 1 releases with `req`=11, the next grant is 01.
- Reset during DRAIN: assert `reset` at DRAIN clock 3 → `grant`=00 and `select_route`=000 immediately; after `reset` is released, `req`=01 is granted one clock later.
